// File: rtl/octree_pkg.sv
// Shared entry-format constants and FSM state type for the octree lookup.
// The internal flag lives at the word MSB, so it is expressed as an offset down from it.
package octree_pkg;

  localparam int unsigned IS_INTERNAL_MSB_OFS = 0;
  localparam int unsigned PTR_LSB             = 0;
  localparam int unsigned MATERIAL_LSB        = 0;
  localparam int unsigned MATERIAL_WIDTH      = 8;

  localparam logic [MATERIAL_WIDTH-1:0] MATERIAL_EMPTY = '0;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

endpackage

// File: rtl/octree_lookup_if.sv
// Node-memory read bus: one request channel with ready, one response channel without.
interface octree_lookup_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  memReqValid;
  logic                  memReqReady;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memRespValid;
  logic [DATA_WIDTH-1:0] memData;

  modport master (
    output memReqValid,
    output memAddr,
    input  memReqReady,
    input  memRespValid,
    input  memData
  );

  modport slave (
    input  memReqValid,
    input  memAddr,
    output memReqReady,
    output memRespValid,
    output memData
  );

endinterface

// File: rtl/octree_cell_bounds.sv
// Combinational cell geometry: child index of q at a level and the bounds of that level's cell.
module octree_cell_bounds #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LEVEL_W = $clog2(WIDTH + 1)
) (
  input  logic [2:0][WIDTH-1:0] q,
  input  logic [LEVEL_W-1:0]    level,
  output logic [2:0]            idx,
  output logic [2:0][WIDTH-1:0] l,
  output logic [2:0][WIDTH-1:0] u
);

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_sel;

  always_comb begin
    w_mask = {WIDTH{1'b1}} >> level;
    // One-hot on bit WIDTH-level; wraps to zero at level 0 so idx is 0 there.
    w_sel  = w_mask + WIDTH'(1);
    for (int i = 0; i < 3; i++) begin
      idx[i] = |(q[i] & w_sel);
      l[i]   = q[i] & ~w_mask;
      u[i]   = q[i] | w_mask;
    end
  end

endmodule

// File: rtl/octree_lookup.sv
// Sparse voxel octree walker: descends from the root to the leaf holding q and reports
// its bounds and material, with at most one node read in flight.
module octree_lookup
  import octree_pkg::*;
#(
  parameter int unsigned  WIDTH      = 16,
  parameter int unsigned  ADDR_WIDTH = 16,
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  ROOT_ADDR  = 0,
  localparam int unsigned LEVEL_W    = $clog2(WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0][WIDTH-1:0] q,
  output logic                  done,
  output logic                  error,
  output logic [2:0][WIDTH-1:0] l,
  output logic [2:0][WIDTH-1:0] u,
  output logic [7:0]            material,
  output logic [LEVEL_W-1:0]    depth,
  octree_lookup_if.master       mem
);

  localparam int unsigned         IS_INTERNAL_BIT = DATA_WIDTH - 1 - IS_INTERNAL_MSB_OFS;
  localparam logic [LEVEL_W-1:0]  MAX_LEVEL       = LEVEL_W'(WIDTH);

  state_e                    r_state, w_state_next;
  logic [2:0][WIDTH-1:0]     r_q, w_q_next;
  logic [ADDR_WIDTH-1:0]     r_base, w_base_next;
  logic [LEVEL_W-1:0]        r_level, w_level_next;
  logic                      r_pending, w_pending_next;
  logic                      r_stale, w_stale_next;
  logic                      r_done, w_done_next;
  logic                      r_error, w_error_next;
  logic [2:0][WIDTH-1:0]     r_l, w_l_next;
  logic [2:0][WIDTH-1:0]     r_u, w_u_next;
  logic [MATERIAL_WIDTH-1:0] r_material, w_material_next;
  logic [LEVEL_W-1:0]        r_depth, w_depth_next;

  logic [2:0]                w_idx;
  logic [2:0][WIDTH-1:0]     w_cell_l;
  logic [2:0][WIDTH-1:0]     w_cell_u;
  logic                      w_accept;
  logic                      w_resp;
  logic                      w_use;
  logic                      w_is_internal;
  logic [ADDR_WIDTH-1:0]     w_ptr;

  octree_cell_bounds #(
    .WIDTH   (WIDTH),
    .LEVEL_W (LEVEL_W)
  ) u_bounds (
    .q     (r_q),
    .level (r_level),
    .idx   (w_idx),
    .l     (w_cell_l),
    .u     (w_cell_u)
  );

  // Address is a pure function of registered state, so it holds while ready is low.
  assign mem.memReqValid = (r_state == StReq) && !r_pending;
  assign mem.memAddr     = r_base + ADDR_WIDTH'(w_idx);

  assign w_accept      = (r_state == StReq) && !r_pending && mem.memReqReady;
  assign w_resp        = mem.memRespValid && r_pending;
  assign w_use         = w_resp && !r_stale && (r_state == StWait);
  assign w_is_internal = mem.memData[IS_INTERNAL_BIT];
  assign w_ptr         = mem.memData[PTR_LSB +: ADDR_WIDTH];

  always_comb begin
    w_state_next    = r_state;
    w_q_next        = r_q;
    w_base_next     = r_base;
    w_level_next    = r_level;
    w_done_next     = r_done;
    w_error_next    = r_error;
    w_l_next        = r_l;
    w_u_next        = r_u;
    w_material_next = r_material;
    w_depth_next    = r_depth;
    w_pending_next  = (r_pending && !w_resp) || w_accept;
    w_stale_next    = r_stale && !w_resp;

    if (start) begin
      w_state_next = StReq;
      w_q_next     = q;
      w_base_next  = ADDR_WIDTH'(ROOT_ADDR);
      w_level_next = LEVEL_W'(1);
      w_done_next  = 1'b0;
      w_error_next = 1'b0;
      // Whatever is still in flight after this edge belongs to the abandoned lookup.
      w_stale_next = w_pending_next;
    end else begin
      unique case (r_state)
        StIdle: ;
        StReq: begin
          if (w_accept) w_state_next = StWait;
        end
        StWait: begin
          if (w_use) begin
            if (!w_is_internal) begin
              w_l_next        = w_cell_l;
              w_u_next        = w_cell_u;
              w_material_next = mem.memData[MATERIAL_LSB +: MATERIAL_WIDTH];
              w_depth_next    = r_level;
              w_done_next     = 1'b1;
              w_state_next    = StIdle;
            end else if (r_level == MAX_LEVEL) begin
              w_error_next    = 1'b1;
              w_material_next = MATERIAL_EMPTY;
              w_l_next        = r_q;
              w_u_next        = r_q;
              w_depth_next    = MAX_LEVEL;
              w_done_next     = 1'b1;
              w_state_next    = StIdle;
            end else begin
              w_base_next  = w_ptr;
              w_level_next = r_level + LEVEL_W'(1);
              w_state_next = StReq;
            end
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_q        <= '0;
      r_base     <= '0;
      r_level    <= '0;
      r_pending  <= 1'b0;
      r_stale    <= 1'b0;
      r_done     <= 1'b1;
      r_error    <= 1'b0;
      r_l        <= '0;
      r_u        <= '0;
      r_material <= MATERIAL_EMPTY;
      r_depth    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_q        <= w_q_next;
      r_base     <= w_base_next;
      r_level    <= w_level_next;
      r_pending  <= w_pending_next;
      r_stale    <= w_stale_next;
      r_done     <= w_done_next;
      r_error    <= w_error_next;
      r_l        <= w_l_next;
      r_u        <= w_u_next;
      r_material <= w_material_next;
      r_depth    <= w_depth_next;
    end
  end

  assign done     = r_done;
  assign error    = r_error;
  assign l        = r_l;
  assign u        = r_u;
  assign material = r_material;
  assign depth    = r_depth;

endmodule

// File: tb/tb_octree_lookup.sv
// Bench for octree_lookup: memory model with optional backpressure, delay and stray responses,
// checked against a plain-arithmetic tree walk.
module tb_octree_lookup;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [2:0][W-1:0] q     = '0;
  logic              done;
  logic              error;
  logic [2:0][W-1:0] l;
  logic [2:0][W-1:0] u;
  logic [7:0]        material;
  logic [4:0]        depth;

  octree_lookup_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  octree_lookup #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ROOT_ADDR  (0)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .q        (q),
    .done     (done),
    .error    (error),
    .l        (l),
    .u        (u),
    .material (material),
    .depth    (depth),
    .mem      (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0       = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model
  logic [31:0] mem_arr [65536];
  logic [15:0] addr_log [$];
  logic        ready_dir  = 1'b1;
  logic        rnd_mode   = 1'b0;
  int          resp_delay = 0;
  logic        ready_rnd  = 1'b1;
  logic        stray_en   = 1'b0;
  int          rnd_dly    = 0;
  int          eff_dly;
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  int          m_cnt   = 0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_word  = '0;

  assign eff_dly          = rnd_mode ? rnd_dly : resp_delay;
  assign bus.memReqReady  = rnd_mode ? ready_rnd : ready_dir;
  assign bus.memRespValid = m_valid | (rnd_mode & stray_en & bus.memReqValid);
  assign bus.memData      = m_valid ? m_data : 32'hDEAD_BEEF;

  always @(posedge clock) begin
    ready_rnd <= ($urandom_range(0, 3) != 0);
    stray_en  <= ($urandom_range(0, 3) == 0);
    rnd_dly   <= int'($urandom_range(0, 2));
  end

  always @(posedge clock) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
      m_cnt   <= 0;
    end else begin
      m_valid <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          m_valid <= 1'b1;
          m_data  <= m_word;
          m_busy  <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (bus.memReqValid && bus.memReqReady) begin
        addr_log.push_back(bus.memAddr);
        if (eff_dly == 0) begin
          m_valid <= 1'b1;
          m_data  <= mem_arr[bus.memAddr];
        end else begin
          m_busy <= 1'b1;
          m_word <= mem_arr[bus.memAddr];
          m_cnt  <= eff_dly - 1;
        end
      end
    end
  end

  // Reference model
  logic [2:0][W-1:0] exp_l, exp_u;
  logic [7:0]        exp_mat;
  logic [4:0]        exp_dep;
  logic              exp_err;
  logic [15:0]       exp_addrs [$];

  task automatic ref_lookup(input logic [2:0][W-1:0] qq);
    int unsigned base;
    base = 0;
    exp_addrs.delete();
    exp_err = 1'b1;
    exp_mat = 8'd0;
    exp_dep = 5'd16;
    exp_l   = qq;
    exp_u   = qq;
    for (int d = 1; d <= 16; d++) begin
      int          b;
      int unsigned idx, addr, span;
      logic [31:0] word;
      b    = 16 - d;
      idx  = int'(qq[0][b]) + 2 * int'(qq[1][b]) + 4 * int'(qq[2][b]);
      addr = (base + idx) % 65536;
      word = mem_arr[addr];
      exp_addrs.push_back(16'(addr));
      if (word[31] == 1'b0) begin
        span = 32'd1 << b;
        for (int i = 0; i < 3; i++) begin
          exp_l[i] = 16'((32'(qq[i]) / span) * span);
          exp_u[i] = 16'(32'(exp_l[i]) + span - 1);
        end
        exp_mat = word[7:0];
        exp_dep = 5'(d);
        exp_err = 1'b0;
        return;
      end
      base = 32'(word[15:0]);
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic start_lookup(input logic [2:0][W-1:0] qq);
    @(negedge clock);
    q     = qq;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    c0    = cyc;
  endtask

  task automatic wait_done(output int cycles);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    cycles = cyc - c0;
    check("done_timeout", 64'(done), 64'(1));
  endtask

  task automatic check_result(input string tag, input int exp_cycles, input int cycles);
    check({tag, "_l"}, 64'(l), 64'(exp_l));
    check({tag, "_u"}, 64'(u), 64'(exp_u));
    check({tag, "_material"}, 64'(material), 64'(exp_mat));
    check({tag, "_depth"}, 64'(depth), 64'(exp_dep));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_nreq"}, 64'(addr_log.size()), 64'(exp_addrs.size()));
    for (int i = 0; i < exp_addrs.size() && i < addr_log.size(); i++)
      check({tag, "_addr"}, 64'(addr_log[i]), 64'(exp_addrs[i]));
    if (exp_cycles >= 0) check({tag, "_cycles"}, 64'(cycles), 64'(exp_cycles));
  endtask

  initial begin
    int                cy;
    int                next_free;
    int                blk;
    logic [2:0][W-1:0] qa, q0, q2;

    for (int a = 0; a < 65536; a++) mem_arr[a] = '0;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    check("rst_done", 64'(done), 64'(1));
    check("rst_error", 64'(error), 64'(0));
    check("rst_l", 64'(l), 64'(0));
    check("rst_u", 64'(u), 64'(0));
    check("rst_material", 64'(material), 64'(0));
    check("rst_depth", 64'(depth), 64'(0));
    check("rst_reqvalid", 64'(bus.memReqValid), 64'(0));
    check("rst_addr", 64'(bus.memAddr), 64'(0));
    reset = 1'b0;

    // Single-level leaf
    qa = {16'h0000, 16'h0000, 16'h8000};
    addr_log.delete();
    ref_lookup(qa);
    start_lookup(qa);
    check("t1_busy", 64'(done), 64'(0));
    wait_done(cy);
    check_result("t1", 2, cy);
    check("t1_l_lit", 64'(l), 64'(48'h0000_0000_8000));
    check("t1_u_lit", 64'(u), 64'(48'h7FFF_7FFF_FFFF));
    check("t1_addr_lit", 64'(addr_log[0]), 64'(1));

    // Two levels
    mem_arr[7]  = 32'h8000_0010;
    mem_arr[16] = 32'h0000_0005;
    q2 = {16'h8000, 16'h8000, 16'h9000};
    addr_log.delete();
    ref_lookup(q2);
    start_lookup(q2);
    wait_done(cy);
    check_result("t2", 4, cy);
    check("t2_u_lit", 64'(u), 64'(48'hBFFF_BFFF_BFFF));
    check("t2_mat_lit", 64'(material), 64'(5));

    // Backpressure at level 2
    addr_log.delete();
    ref_lookup(q2);
    start_lookup(q2);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    ready_dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 64'(bus.memReqValid), 64'(1));
      check("bp_addr", 64'(bus.memAddr), 64'(16'h0010));
      @(posedge clock);
      #1;
    end
    ready_dir = 1'b1;
    wait_done(cy);
    check_result("bp", 7, cy);

    // Restart while waiting; the stale response lands one cycle after the restart
    mem_arr[0] = 32'h0000_0003;
    q0 = '0;
    resp_delay = 1;
    addr_log.delete();
    start_lookup(q2);
    @(posedge clock);
    #1;
    resp_delay = 0;
    addr_log.delete();
    ref_lookup(q0);
    start_lookup(q0);
    check("rs_gated", 64'(bus.memReqValid), 64'(0));
    wait_done(cy);
    check_result("rs", 3, cy);

    // Depth overflow
    for (int a = 0; a < 8; a++) mem_arr[a] = 32'h8000_0000;
    qa = {16'($urandom), 16'($urandom), 16'($urandom)};
    addr_log.delete();
    ref_lookup(qa);
    start_lookup(qa);
    wait_done(cy);
    check_result("ov", 32, cy);
    check("ov_error_lit", 64'(error), 64'(1));
    check("ov_l_is_q", 64'(l), 64'(qa));

    // Reset during REQ
    start_lookup({16'h1234, 16'h5678, 16'h9ABC});
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mr_done", 64'(done), 64'(1));
    check("mr_reqvalid", 64'(bus.memReqValid), 64'(0));
    check("mr_l", 64'(l), 64'(0));
    check("mr_u", 64'(u), 64'(0));
    check("mr_material", 64'(material), 64'(0));
    check("mr_depth", 64'(depth), 64'(0));
    check("mr_error", 64'(error), 64'(0));
    reset = 1'b0;

    // Random tree, breadth-first allocation with junk in unused entry bits
    for (int a = 0; a < 512; a++) mem_arr[a] = '0;
    next_free = 8;
    blk = 0;
    while (blk < next_free) begin
      for (int e = 0; e < 8; e++) begin
        if ($urandom_range(0, 2) == 0 && next_free < 320) begin
          mem_arr[blk + e] = {1'b1, 15'($urandom), 16'(next_free)};
          next_free += 8;
        end else begin
          mem_arr[blk + e] = {1'b0, 23'($urandom), 8'($urandom)};
        end
      end
      blk += 8;
    end

    for (int k = 0; k < 8; k++) begin
      qa = {16'($urandom), 16'($urandom), 16'($urandom)};
      addr_log.delete();
      ref_lookup(qa);
      start_lookup(qa);
      wait_done(cy);
      check_result("rz", 2 * int'(exp_dep), cy);
    end

    rnd_mode = 1'b1;
    for (int k = 0; k < 12; k++) begin
      qa = {16'($urandom), 16'($urandom), 16'($urandom)};
      addr_log.delete();
      ref_lookup(qa);
      start_lookup(qa);
      wait_done(cy);
      check_result("rr", -1, cy);
    end
    rnd_mode = 1'b0;

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
